// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX->MEM pipeline register with stall hold, bubble, flush, valid bit and multi-cycle feedback (optional EXMEM_BUBBLE_CNT_EN bubble counter)
module ex_mem_stage_reg #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ex,
    input  logic              stall_mem,
    input  logic              flush,
    input  logic [AW-1:0]     ex_wd,
    input  logic              ex_wreg,
    input  logic [DW-1:0]     ex_wdata,
    input  logic              ex_whilo,
    input  logic [DW-1:0]     ex_hi,
    input  logic [DW-1:0]     ex_lo,
    input  logic [2*DW-1:0]   hilo_temp_i,
    input  logic [CNTW-1:0]   cnt_i,
    output logic [AW-1:0]     mem_wd,
    output logic              mem_wreg,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_whilo,
    output logic [DW-1:0]     mem_hi,
    output logic [DW-1:0]     mem_lo,
    output logic              mem_valid,
    output logic [2*DW-1:0]   hilo_temp_o,
    output logic [CNTW-1:0]   cnt_o
`ifdef EXMEM_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    // MEM slot: clear on reset/flush, keep while MEM stalls, bubble while only EX stalls, else capture EX
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_valid <= 1'b0;
        end else if (stall_mem) begin
            // also covers the unused stall_ex=0/stall_mem=1 combination
            mem_wd    <= mem_wd;
            mem_wreg  <= mem_wreg;
            mem_wdata <= mem_wdata;
            mem_whilo <= mem_whilo;
            mem_hi    <= mem_hi;
            mem_lo    <= mem_lo;
            mem_valid <= mem_valid;
        end else if (stall_ex) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_valid <= 1'b0;
        end else begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            mem_valid <= 1'b1;
        end
    end

    // Accumulate feedback: echo EX state while stalled, drop it once the op passes or is killed
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else if (stall_ex || stall_mem) begin
            hilo_temp_o <= hilo_temp_i;
            cnt_o       <= cnt_i;
        end else begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end
    end

`ifdef EXMEM_BUBBLE_CNT_EN
    // Saturating count of bubble cycles; survives flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && stall_ex && !stall_mem && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // ctrl never stalls MEM without EX; flag it if it ever does
    always @(posedge clk) begin
        if (!rst && !flush && !stall_ex && stall_mem)
            $error("ex_mem_stage_reg: stall_mem without stall_ex");
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - randomized model-checked bench for ex_mem_stage_reg
module tb_ex_mem_stage_reg;

    localparam int DW = 32, AW = 5, CNTW = 2;

    logic            clk = 1'b0;
    logic            rst, stall_ex, stall_mem, flush;
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg, ex_whilo;
    logic [DW-1:0]   ex_wdata, ex_hi, ex_lo;
    logic [2*DW-1:0] hilo_temp_i;
    logic [CNTW-1:0] cnt_i;
    logic [AW-1:0]   mem_wd;
    logic            mem_wreg, mem_whilo, mem_valid;
    logic [DW-1:0]   mem_wdata, mem_hi, mem_lo;
    logic [2*DW-1:0] hilo_temp_o;
    logic [CNTW-1:0] cnt_o;
`ifdef EXMEM_BUBBLE_CNT_EN
    logic [15:0]     bubble_cnt;
    int              m_bc;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model: the instruction bundle sitting in MEM and the feedback pair
    typedef struct packed {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic          whilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          valid;
    } slot_t;

    slot_t           m_slot;
    logic [2*DW-1:0] m_hilo;
    logic [CNTW-1:0] m_cnt;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
`ifdef EXMEM_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("wd", 64'(mem_wd), 64'(m_slot.wd));
        check("wreg", 64'(mem_wreg), 64'(m_slot.wreg));
        check("wdata", 64'(mem_wdata), 64'(m_slot.wdata));
        check("whilo", 64'(mem_whilo), 64'(m_slot.whilo));
        check("hi", 64'(mem_hi), 64'(m_slot.hi));
        check("lo", 64'(mem_lo), 64'(m_slot.lo));
        check("valid", 64'(mem_valid), 64'(m_slot.valid));
        check("hilo_temp", 64'(hilo_temp_o), 64'(m_hilo));
        check("cnt", 64'(cnt_o), 64'(m_cnt));
`ifdef EXMEM_BUBBLE_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
`endif
    endtask

    // advance one clock: update the model from the applied inputs, then compare
    task automatic step();
        slot_t incoming;
        incoming = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                     hi: ex_hi, lo: ex_lo, valid: 1'b1};
        if (rst || flush) begin
            m_slot = '0;
            m_hilo = '0;
            m_cnt  = '0;
`ifdef EXMEM_BUBBLE_CNT_EN
            if (rst) m_bc = 0;
`endif
        end else if (stall_ex && stall_mem) begin
            m_hilo = hilo_temp_i;
            m_cnt  = cnt_i;
        end else if (stall_ex) begin
            m_slot = '0;
            m_hilo = hilo_temp_i;
            m_cnt  = cnt_i;
`ifdef EXMEM_BUBBLE_CNT_EN
            if (m_bc < 65535) m_bc = m_bc + 1;
`endif
        end else begin
            m_slot = incoming;
            m_hilo = '0;
            m_cnt  = '0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rand_ex();
        ex_wd       = AW'($urandom);
        ex_wreg     = 1'($urandom);
        ex_wdata    = $urandom;
        ex_whilo    = 1'($urandom);
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        hilo_temp_i = {$urandom, $urandom};
        cnt_i       = CNTW'($urandom);
    endtask

    task automatic ctl(input logic r, input logic f, input logic se, input logic sm);
        rst = r; flush = f; stall_ex = se; stall_mem = sm;
    endtask

    initial begin
        m_slot = '0; m_hilo = '0; m_cnt = '0;
`ifdef EXMEM_BUBBLE_CNT_EN
        m_bc = 0;
`endif
        // reset with every EX field driven to all-ones
        ctl(1, 0, 0, 0);
        ex_wd = '1; ex_wreg = 1; ex_wdata = '1; ex_whilo = 1; ex_hi = '1; ex_lo = '1;
        hilo_temp_i = '1; cnt_i = '1;
        step();
        step();
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_cnt", 64'(cnt_o), 64'd0);

        // plain pass
        ctl(0, 0, 0, 0);
        rand_ex();
        ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'hDEADBEEF;
        step();
        check("pass_wd", 64'(mem_wd), 64'd3);
        check("pass_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("pass_hilo", hilo_temp_o, 64'd0);

        // bubble carrying a partial product, then release
        ctl(0, 0, 1, 0);
        cnt_i = 2'd1; hilo_temp_i = 64'h1_0000_0002;
        step();
        check("bub_valid", 64'(mem_valid), 64'd0);
        check("bub_cnt", 64'(cnt_o), 64'd1);
        check("bub_hilo", hilo_temp_o, 64'h1_0000_0002);
        ctl(0, 0, 0, 0);
        step();
        check("rel_cnt", 64'(cnt_o), 64'd0);
        check("rel_hilo", hilo_temp_o, 64'd0);

        // hold keeps the old instruction in MEM
        ex_wdata = 32'h11;
        step();
        ctl(0, 0, 1, 1);
        ex_wdata = 32'h22;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_wdata", 64'(mem_wdata), 64'h11);
        end
        ctl(0, 0, 0, 0);
        step();
        check("hold_rel_wdata", 64'(mem_wdata), 64'h22);

        // flush overrides a full stall
        ctl(0, 1, 1, 1);
        cnt_i = 2'd3;
        step();
        check("flush_valid", 64'(mem_valid), 64'd0);
        check("flush_cnt", 64'(cnt_o), 64'd0);

`ifdef EXMEM_BUBBLE_CNT_EN
        ctl(1, 0, 0, 0);
        step();
        ctl(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step();
        ctl(0, 1, 0, 0);
        step();
        check("bc_after_flush", 64'(bubble_cnt), 64'd4);
        ctl(1, 0, 0, 0);
        step();
        check("bc_rst", 64'(bubble_cnt), 64'd0);
`endif

        // randomized legal traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rand_ex();
            if (r < 3)       ctl(1, 1'($urandom), 1'($urandom), 0);
            else if (r < 8)  begin
                ctl(0, 1, 1'($urandom), 0);
                if (stall_ex) stall_mem = 1'($urandom);
            end
            else if (r < 30) ctl(0, 0, 1, 1);
            else if (r < 55) ctl(0, 0, 1, 0);
            else             ctl(0, 0, 0, 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
